dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
// - Memory-side responder for the core's data bus: accepts one dbus request at a time, models fixed access
//   latency, performs byte-strobed 64-bit writes / full-word reads on an internal SRAM array, answers with
//   addr_ok / data_ok pulses. Sits opposite the core's dreq/dresp ports in the sim top; stand-in for the
//   real memory system during pipeline bring-up (load/store, stall logic).
// PARAMETERS
// - DEPTH_WORDS  4096            number of 64-bit words in the array
// - LATENCY      2               edges from acceptance to data_ok; legal range 1..15
// - BASE_ADDR    64'h8000_0000   byte address mapped to word 0
// PORTS
// - clk          in   1   clock
// - reset        in   1   asynchronous, active-low reset
// - req_valid    in   1   request valid; initiator holds it and all request fields stable until data_ok
// - req_addr     in   64  byte address; [2:0] ignored for indexing
// - req_size     in   3   access size (log2 bytes); informational only, strobe governs writes
// - req_strobe   in   8   byte-lane write enables; 8'h00 = read
// - req_data     in   64  write data, lane-aligned
// - resp_addr_ok out  1   one-cycle pulse: request accepted
// - resp_data_ok out  1   one-cycle pulse: access complete, resp_data valid
// - resp_data    out  64  read data (full aligned word, also returned for writes as pre-write value)
// - busy         out  1   high in any state other than IDLE
// - bad_addr     out  1   sticky: set by any access outside the array; cleared only by reset
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, cnt=0, resp_addr_ok=0, resp_data_ok=0, resp_data=0, busy=0,
//   bad_addr=0; captured request discarded; SRAM contents NOT cleared.
// - All outputs registered; no combinational path from request inputs to outputs.
// - FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: at an edge with req_valid=1, latch addr/strobe/data, cnt<=LATENCY-1, resp_addr_ok<=1, go BUSY.
//   BUSY: resp_addr_ok<=0. If cnt==0: do access, resp_data_ok<=1, go DONE; else cnt<=cnt-1.
//   DONE: resp_data_ok<=0, go IDLE; req_valid ignored in DONE.
// - Timing: acceptance at edge E0 -> addr_ok high during cycle after E0 -> data_ok high during cycle
//   after E(LATENCY) -> next request accepted earliest at E(LATENCY+2).
// - Index = (addr - BASE_ADDR) >> 3, 64-bit unsigned subtraction; in range iff addr >= BASE_ADDR and
//   index < DEPTH_WORDS. Below-base addresses wrap to huge values and count as out of range.
// - Access: resp_data <= mem[index]; for each lane i with strobe[i]=1,
//   mem[index][8i+7:8i] <= data[8i+7:8i]. Read and write in the same edge; resp_data is pre-write value.
// - Out of range: no write, resp_data <= 0, bad_addr <= 1; handshake timing unchanged.
// - req_valid dropping or request fields changing during BUSY: protocol violation; the latched request
//   completes normally and the change is ignored.
// - Reset asserted mid-BUSY: the pending write is not performed; no data_ok is produced.
// - resp_data holds its value after data_ok until the next access completes.
// TESTING
// - Write then read, LATENCY=2: addr 0x8000_0010, strobe 8'hFF, data 0x1122334455667788 -> addr_ok 1
//   cycle after accept, data_ok 2 edges after accept. Read same addr -> resp_data=0x1122334455667788.
// - Partial strobe: over the word above, write strobe 8'h0F, data 0xAAAAAAAA_BBBBBBBB, then read ->
//   0x11223344_BBBBBBBB.
// - Out of range: read 0x7FFF_FFF8 and write BASE+8*DEPTH_WORDS -> resp_data=0, bad_addr=1 and sticky,
//   no array word modified, handshake timing unchanged.
// - Back-to-back with LATENCY=1: hold req_valid continuously with new request right after data_ok ->
//   exactly one addr_ok/data_ok pair per request; next addr_ok 3 edges after the previous one; no
//   double-accept during DONE.
// - Reset mid-BUSY: drop reset during a write with cnt>0 -> outputs 0 immediately (async), word
//   unchanged, next request served normally.
// - Index boundaries: write/read word 0 and word DEPTH_WORDS-1 -> correct data, bad_addr stays 0.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// +----------------------------------------------------------------------------+
// | Module  : dbus_sram_responder                                               |
// | Brief   : Fixed-latency data-bus SRAM responder with byte-strobed writes.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module dbus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        busy,
  output logic        bad_addr
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [60:0] DEPTH_L  = 61'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  strobe_q, strobe_d;
  logic [63:0] wdata_q, wdata_d;
  logic        addr_ok_q, addr_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [63:0] rdata_q, rdata_d;
  logic        bad_q, bad_d;

  logic [63:0] mem [DEPTH_WORDS];
  logic [63:0] offset;
  logic [IDX_W-1:0] idx;
  logic        in_range;
  logic        mem_we;
  logic [63:0] mem_rd;
  logic [63:0] mem_wr;
  logic        unused_ok;

  // Below-base addresses wrap to huge offsets, so the explicit >= test is kept.
  assign offset    = addr_q - BASE_ADDR;
  assign idx       = offset[IDX_W+2:3];
  assign in_range  = (addr_q >= BASE_ADDR) && (offset[63:3] < DEPTH_L);
  assign mem_rd    = mem[idx];
  assign unused_ok = ^{req_size, offset[2:0]};

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_wr[8*i +: 8] = strobe_q[i] ? wdata_q[8*i +: 8] : mem_rd[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;
    addr_ok_d = 1'b0;
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    bad_d     = bad_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          strobe_d  = req_strobe;
          wdata_d   = req_data;
          cnt_d     = CNT_INIT;
          addr_ok_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          data_ok_d = 1'b1;
          state_d   = DONE;
          if (in_range) begin
            rdata_d = mem_rd;
            mem_we  = 1'b1;
          end else begin
            rdata_d = 64'd0;
            bad_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 64'd0;
      strobe_q  <= 8'd0;
      wdata_q   <= 64'd0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      rdata_q   <= 64'd0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      strobe_q  <= strobe_d;
      wdata_q   <= wdata_d;
      addr_ok_q <= addr_ok_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
      bad_q     <= bad_d;
    end
  end

  // Array has no reset; write enable derives from state_q, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= mem_wr;
    end
  end

  assign resp_addr_ok = addr_ok_q;
  assign resp_data_ok = data_ok_q;
  assign resp_data    = rdata_q;
  assign busy         = (state_q != IDLE);
  assign bad_addr     = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_dbus_sram_responder                                            |
// | Brief   : Randomized bench for two responders (LATENCY 2 and 1) vs. model.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dbus_sram_responder;

  localparam int          DEPTH = 256;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid;
  logic [63:0] req_addr   [2];
  logic [2:0]  req_size   [2];
  logic [7:0]  req_strobe [2];
  logic [63:0] req_data   [2];
  logic [1:0]  addr_ok, data_ok, busy, bad;
  logic [63:0] rdata [2];

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_dut_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_size(req_size[0]), .req_strobe(req_strobe[0]), .req_data(req_data[0]),
    .resp_addr_ok(addr_ok[0]), .resp_data_ok(data_ok[0]), .resp_data(rdata[0]),
    .busy(busy[0]), .bad_addr(bad[0])
  );

  dbus_sram_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_size(req_size[1]), .req_strobe(req_strobe[1]), .req_data(req_data[1]),
    .resp_addr_ok(addr_ok[1]), .resp_data_ok(data_ok[1]), .resp_data(rdata[1]),
    .busy(busy[1]), .bad_addr(bad[1])
  );

  int          checks = 0;
  int          errors = 0;
  int          lat [2] = '{2, 1};
  logic [63:0] ref_mem [2][DEPTH];
  bit          ref_bad [2];
  bit          kept    [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  // One complete transaction; keep=1 leaves req_valid high for an immediate follow-on request.
  task automatic access(input int d, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] wd, input bit keep, output logic [63:0] rd);
    logic [63:0] exp_rd;
    int          idx, e_aok, e_dok, n_aok, first;
    if (in_rng(a)) begin
      idx    = int'((a - BASE) / 64'd8);
      exp_rd = ref_mem[d][idx];
      for (int i = 0; i < 8; i++)
        if (s[i]) ref_mem[d][idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      exp_rd   = 64'd0;
      ref_bad[d] = 1'b1;
    end
    first = kept[d] ? 2 : 1;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_addr[d]   = a;
    req_strobe[d] = s;
    req_data[d]   = wd;
    req_size[d]   = 3'd3;
    e_aok = 0; e_dok = 0; n_aok = 0; rd = 64'd0;
    for (int e = 1; e <= lat[d] + 6 && e_dok == 0; e++) begin
      @(posedge clk); #1;
      if (addr_ok[d]) begin
        n_aok++;
        if (e_aok == 0) e_aok = e;
        if (e == first) check_val("busy_after_accept", 64'(busy[d]), 64'd1);
      end
      if (data_ok[d]) begin
        e_dok = e;
        rd    = rdata[d];
      end
    end
    check_val("addr_ok_edge", 64'(e_aok), 64'(first));
    check_val("data_ok_edge", 64'(e_dok), 64'(first + lat[d]));
    check_val("addr_ok_count", 64'(n_aok), 64'd1);
    check_val("resp_data", rd, exp_rd);
    check_val("bad_addr", 64'(bad[d]), 64'(ref_bad[d]));
    kept[d] = keep;
    if (!keep) begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      @(posedge clk); #1;
      check_val("pulses_low", 64'({addr_ok[d], data_ok[d], busy[d]}), 64'd0);
      check_val("resp_data_hold", rdata[d], rd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, a, wd;
    logic [7:0]  s;
    int          d, k;

    reset     = 1'b0;
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_size[i] = '0; req_strobe[i] = '0; req_data[i] = '0;
      ref_bad[i] = 1'b0; kept[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val("reset_flags", 64'({addr_ok[i], data_ok[i], busy[i], bad[i]}), 64'd0);
      check_val("reset_data", rdata[i], 64'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    // Fill both arrays so every later read has a known expected value.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++)
        access(i, BASE + 64'(w) * 8, 8'hFF, {$urandom, $urandom}, (i == 1) && (w != DEPTH - 1), rd);

    access(0, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0, rd);
    access(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0, rd);
    check_val("full_write_read", rd, 64'h1122334455667788);
    access(0, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, rd);
    check_val("partial_prewrite", rd, 64'h1122334455667788);
    access(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0, rd);
    check_val("partial_read", rd, 64'h11223344_BBBBBBBB);

    access(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 1'b0, rd);
    check_val("below_base_data", rd, 64'd0);
    check_val("below_base_bad", 64'(bad[0]), 64'd1);
    access(0, BASE + 64'(DEPTH) * 8, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, rd);
    check_val("above_top_data", rd, 64'd0);
    access(0, BASE + 64'h18, 8'h00, 64'h0, 1'b0, rd);
    check_val("bad_sticky", 64'(bad[0]), 64'd1);

    access(1, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, rd);
    access(1, BASE, 8'h00, 64'h0, 1'b0, rd);
    check_val("word0", rd, 64'h0123_4567_89AB_CDEF);
    access(1, BASE + 64'(DEPTH - 1) * 8, 8'hFF, 64'hFEDC_BA98_7654_3210, 1'b0, rd);
    access(1, BASE + 64'(DEPTH - 1) * 8 + 7, 8'h00, 64'h0, 1'b0, rd);
    check_val("word_last", rd, 64'hFEDC_BA98_7654_3210);
    check_val("boundary_bad", 64'(bad[1]), 64'd0);

    // Back-to-back on the LATENCY=1 instance with req_valid held throughout.
    for (int n = 0; n < 24; n++) begin
      a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
      s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      access(1, a, s, {$urandom, $urandom}, n != 23, rd);
    end

    for (int n = 0; n < 300; n++) begin
      d = $urandom_range(0, 1);
      k = $urandom_range(0, 9);
      if (k == 0)      a = BASE - 64'($urandom_range(1, 1000)) * 8 - 64'($urandom_range(0, 7));
      else if (k == 1) a = BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 8000));
      else             a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(0, 7));
      s  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      wd = {$urandom, $urandom};
      access(d, a, s, wd, 1'b0, rd);
    end

    // Reset during a pending LATENCY=2 write: nothing is written, outputs clear at once.
    a = BASE + 64'h40;
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = a; req_strobe[0] = 8'hFF; req_data[0] = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    check_val("rst_busy_accept", 64'(addr_ok[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check_val("rst_async_flags", 64'({addr_ok[0], data_ok[0], busy[0], bad[0]}), 64'd0);
    check_val("rst_async_data", rdata[0], 64'd0);
    req_valid[0] = 1'b0;
    ref_bad[0] = 1'b0; ref_bad[1] = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    access(0, a, 8'h00, 64'h0, 1'b0, rd);
    check_val("rst_no_write", 64'(rd == 64'h5555_6666_7777_8888), 64'd0);

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++)
        access(i, BASE + 64'(w) * 8, 8'h00, 64'h0, (i == 1) && (w != DEPTH - 1), rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
